// File: rtl/bus_xbar_pkg.sv
// Shared types and constants for the request/grant crossbar.
package bus_xbar_pkg;

    typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_e;

    localparam logic [31:0] ERR_RDATA = 32'hBADA_CCE5;

    // One extra code beyond the slave indices is kept to mean "unmapped".
    function automatic int slave_idx_width(input int n);
        int w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Per-slave arbiter: fixed-priority or round-robin with a last-winner pointer.
module rr_arbiter
    import bus_xbar_pkg::*;
#(
    parameter int        N    = 2,
    parameter arb_mode_e MODE = ARB_RR,
    localparam int       IW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

    logic [IW-1:0] r_ptr;
    logic          w_found;
    int            w_c;

    // Search starts one past the last winner; fixed mode always starts at 0.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        w_found = 1'b0;
        w_c     = 0;
        for (int k = 0; k < N; k++) begin
            if (MODE == ARB_FIXED) w_c = k;
            else                   w_c = (int'(r_ptr) + 1 + k) % N;
            if (!w_found && req_i[w_c]) begin
                w_found    = 1'b1;
                gnt_o[w_c] = 1'b1;
                idx_o      = IW'(w_c);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_ptr <= IW'(N - 1);
        else if (w_found) r_ptr <= idx_o;
    end

endmodule

// File: rtl/bus_xbar.sv
// N-master / M-slave crossbar: address decode, per-slave arbitration,
// slave request muxing and single-cycle response return.
module bus_xbar
    import bus_xbar_pkg::*;
#(
    parameter int        N_MASTERS        = 2,
    parameter int        N_SLAVES         = 3,
    parameter int        ADDR_WIDTH       = 32,
    parameter int        DATA_WIDTH       = 32,
    parameter int        SLAVE_ADDR_WIDTH = 16,
    parameter logic [N_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE =
        {32'h1A10_0000, 32'h0010_0000, 32'h1000_0000},
    parameter logic [N_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK =
        {32'hFFFF_F000, 32'hFFFF_0000, 32'hFFFF_0000},
    parameter arb_mode_e ARB_MODE         = ARB_RR
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [N_MASTERS-1:0]                 m_req_i,
    output logic [N_MASTERS-1:0]                 m_gnt_o,
    output logic [N_MASTERS-1:0]                 m_rvalid_o,
    output logic [N_MASTERS-1:0]                 m_err_o,
    input  logic [N_MASTERS-1:0]                 m_we_i,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0]      m_addr_i,
    input  logic [N_MASTERS*DATA_WIDTH/8-1:0]    m_be_i,
    input  logic [N_MASTERS*DATA_WIDTH-1:0]      m_wdata_i,
    output logic [N_MASTERS*DATA_WIDTH-1:0]      m_rdata_o,
    output logic [N_SLAVES-1:0]                  s_en_o,
    output logic [N_SLAVES-1:0]                  s_we_o,
    output logic [N_SLAVES*SLAVE_ADDR_WIDTH-1:0] s_addr_o,
    output logic [N_SLAVES*DATA_WIDTH/8-1:0]     s_be_o,
    output logic [N_SLAVES*DATA_WIDTH-1:0]       s_wdata_o,
    input  logic [N_SLAVES*DATA_WIDTH-1:0]       s_rdata_i
);

    localparam int SIW = slave_idx_width(N_SLAVES);
    localparam int MIW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int BW  = DATA_WIDTH / 8;
    localparam int SAW = SLAVE_ADDR_WIDTH;
    localparam int DW  = DATA_WIDTH;
    localparam logic [DW-1:0] ERR_D = DW'(ERR_RDATA);

    logic [N_MASTERS-1:0][SIW-1:0]      w_dec;
    logic [N_MASTERS-1:0]               w_unmap;
    logic [N_MASTERS-1:0]               w_gnt;
    logic [N_SLAVES-1:0][N_MASTERS-1:0] w_sreq;
    logic [N_SLAVES-1:0][N_MASTERS-1:0] w_sgnt;
    logic [N_SLAVES-1:0][MIW-1:0]       w_sidx;

    logic [N_MASTERS-1:0]               r_rvalid;
    logic [N_MASTERS-1:0]               r_err;
    logic [N_MASTERS-1:0]               r_we;
    logic [N_MASTERS-1:0][SIW-1:0]      r_src;

    // Scan from the top down so the lowest matching window wins.
    always_comb begin
        w_dec   = '0;
        w_unmap = '0;
        w_sreq  = '0;
        for (int m = 0; m < N_MASTERS; m++) begin
            w_dec[m] = SIW'(N_SLAVES);
            for (int s = N_SLAVES - 1; s >= 0; s--)
                if ((m_addr_i[m*ADDR_WIDTH +: ADDR_WIDTH] & SLAVE_MASK[s*ADDR_WIDTH +: ADDR_WIDTH])
                    == SLAVE_BASE[s*ADDR_WIDTH +: ADDR_WIDTH])
                    w_dec[m] = SIW'(s);
            w_unmap[m] = (w_dec[m] == SIW'(N_SLAVES));
            for (int s = 0; s < N_SLAVES; s++)
                w_sreq[s][m] = m_req_i[m] && (w_dec[m] == SIW'(s));
        end
    end

    for (genvar s = 0; s < N_SLAVES; s++) begin : g_arb
        rr_arbiter #(.N(N_MASTERS), .MODE(ARB_MODE)) u_arb (
            .clk   (clk),
            .rst   (rst),
            .req_i (w_sreq[s]),
            .gnt_o (w_sgnt[s]),
            .idx_o (w_sidx[s])
        );
    end

    always_comb begin
        w_gnt     = '0;
        s_en_o    = '0;
        s_we_o    = '0;
        s_addr_o  = '0;
        s_be_o    = '0;
        s_wdata_o = '0;
        if (!rst) begin
            w_gnt = m_req_i & w_unmap;
            for (int s = 0; s < N_SLAVES; s++) begin
                w_gnt = w_gnt | w_sgnt[s];
                if (|w_sreq[s]) begin
                    s_en_o[s]                 = 1'b1;
                    s_we_o[s]                 = m_we_i[w_sidx[s]];
                    s_addr_o[s*SAW +: SAW]    = m_addr_i[w_sidx[s]*ADDR_WIDTH +: SAW];
                    s_be_o[s*BW +: BW]        = m_be_i[w_sidx[s]*BW +: BW];
                    s_wdata_o[s*DW +: DW]     = m_wdata_i[w_sidx[s]*DW +: DW];
                end
            end
        end
    end

    assign m_gnt_o = w_gnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rvalid <= '0;
            r_err    <= '0;
            r_we     <= '0;
            r_src    <= '0;
        end else begin
            r_rvalid <= w_gnt;
            r_err    <= w_gnt & w_unmap;
            r_we     <= m_we_i;
            r_src    <= w_dec;
        end
    end

    always_comb begin
        m_rvalid_o = r_rvalid;
        m_err_o    = r_rvalid & r_err;
        m_rdata_o  = '0;
        for (int m = 0; m < N_MASTERS; m++) begin
            if (r_rvalid[m]) begin
                if (r_err[m]) m_rdata_o[m*DW +: DW] = ERR_D;
                else if (!r_we[m])
                    for (int s = 0; s < N_SLAVES; s++)
                        if (r_src[m] == SIW'(s)) m_rdata_o[m*DW +: DW] = s_rdata_i[s*DW +: DW];
            end
        end
    end

endmodule
